// File: rtl/parity_pkg.sv
// Shared definitions for the parity_gen / parity_chk pair.
// Holds the state encoding, the default frame width and the parity-sense selectors.
package parity_pkg;

   typedef enum logic {
      S_DATA = 1'b0,
      S_PAR  = 1'b1
   } state_t;

   localparam int DEF_DATA_BITS = 3;

   localparam int PAR_EVEN = 0;
   localparam int PAR_ODD  = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at all-ones instead of wrapping.
// Only the async reset brings it back to zero.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (inc && (r_count != {W{1'b1}}))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;

endmodule

// File: rtl/parity_chk.sv
// Serial parity checker: deserializes MSB-first frames of DATA_BITS data bits plus
// one parity bit, pulses data_valid/par_err per frame and keeps a saturating error count.
//
//   state  | meaning
//   S_DATA | collecting data bits, r_bit_cnt = index of the next data bit
//   S_PAR  | all data bits held in r_sr, next accepted bit is the parity bit
module parity_chk
   import parity_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int ODD_PARITY = PAR_EVEN,
   parameter int ERR_CNT_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w,
   input  logic                 w_valid,
   input  logic                 resync,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 par_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int              CNT_W      = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_BITS - 1);
   localparam logic            PAR_TARGET = (ODD_PARITY == PAR_ODD);

   state_t                 r_state, w_state_nx;
   logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nx;
   logic [DATA_BITS-1:0]   r_sr, w_sr_nx;
   logic                   r_par, w_par_nx;
   logic [DATA_BITS-1:0]   r_data_out, w_data_out_nx;
   logic                   r_data_valid, w_data_valid_nx;
   logic                   r_par_err, w_par_err_nx;
   logic                   w_err_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_DATA;
         r_bit_cnt    <= '0;
         r_sr         <= '0;
         r_par        <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_bit_cnt    <= w_bit_cnt_nx;
         r_sr         <= w_sr_nx;
         r_par        <= w_par_nx;
         r_data_out   <= w_data_out_nx;
         r_data_valid <= w_data_valid_nx;
         r_par_err    <= w_par_err_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_bit_cnt_nx    = r_bit_cnt;
      w_sr_nx         = r_sr;
      w_par_nx        = r_par;
      w_data_out_nx   = r_data_out;
      w_data_valid_nx = 1'b0;
      w_par_err_nx    = 1'b0;
      w_err_inc       = 1'b0;

      // resync outranks a bit on the same edge, including a parity bit
      if (resync) begin
         w_state_nx   = S_DATA;
         w_bit_cnt_nx = '0;
         w_sr_nx      = '0;
         w_par_nx     = 1'b0;
      end else if (w_valid) begin
         case (r_state)
            S_DATA: begin
               w_sr_nx  = {r_sr[DATA_BITS-2:0], w};
               w_par_nx = r_par ^ w;
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_nx   = S_PAR;
                  w_bit_cnt_nx = '0;
               end else begin
                  w_bit_cnt_nx = r_bit_cnt + 1'b1;
               end
            end
            S_PAR: begin
               w_data_out_nx   = r_sr;
               w_data_valid_nx = 1'b1;
               w_par_err_nx    = ((r_par ^ w) != PAR_TARGET);
               w_err_inc       = w_par_err_nx;
               w_sr_nx         = '0;
               w_par_nx        = 1'b0;
               w_state_nx      = S_DATA;
            end
         endcase
      end
   end

   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_err_inc),
      .count (err_count)
   );

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign par_err    = r_par_err;

endmodule

// File: tb/tb_parity_chk.sv
// Directed bench for parity_chk: an even/4-bit-count instance and an odd/2-bit-count instance,
// with expected frames queued at stimulus time and popped when data_valid is seen.
module tb_parity_chk;

   typedef struct {
      logic [2:0] d;
      logic       pe;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_e, w_e, wv_e, rs_e;
   logic       rst_o, w_o, wv_o, rs_o;
   logic [2:0] dout_e, dout_o;
   logic       dv_e, dv_o, pe_e, pe_o;
   logic [3:0] cnt_e;
   logic [1:0] cnt_o;

   exp_t       q_e[$];
   exp_t       q_o[$];
   logic [2:0] last_e = 3'b000;
   logic [2:0] last_o = 3'b000;
   int         mcnt_e = 0;
   int         mcnt_o = 0;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   parity_chk #(.DATA_BITS(3), .ODD_PARITY(0), .ERR_CNT_W(4)) u_even (
      .clk(clk), .rst(rst_e), .w(w_e), .w_valid(wv_e), .resync(rs_e),
      .data_out(dout_e), .data_valid(dv_e), .par_err(pe_e), .err_count(cnt_e)
   );

   parity_chk #(.DATA_BITS(3), .ODD_PARITY(1), .ERR_CNT_W(2)) u_odd (
      .clk(clk), .rst(rst_o), .w(w_o), .w_valid(wv_o), .resync(rs_o),
      .data_out(dout_o), .data_valid(dv_o), .par_err(pe_o), .err_count(cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin : mon_e
      exp_t e;
      if (dv_e) begin
         if (q_e.size() == 0) chk("e_unexpected_valid", 32'(dv_e), 0);
         else begin
            e = q_e.pop_front();
            chk("e_data", 32'(dout_e), 32'(e.d));
            chk("e_par_err", 32'(pe_e), 32'(e.pe));
            chk("e_err_count", 32'(cnt_e), 32'(e.cnt));
            last_e = e.d;
         end
      end else begin
         chk("e_par_err_idle", 32'(pe_e), 0);
         chk("e_data_hold", 32'(dout_e), 32'(last_e));
      end
   end

   always @(negedge clk) begin : mon_o
      exp_t e;
      if (dv_o) begin
         if (q_o.size() == 0) chk("o_unexpected_valid", 32'(dv_o), 0);
         else begin
            e = q_o.pop_front();
            chk("o_data", 32'(dout_o), 32'(e.d));
            chk("o_par_err", 32'(pe_o), 32'(e.pe));
            chk("o_err_count", 32'(cnt_o), 32'(e.cnt));
            last_o = e.d;
         end
      end else begin
         chk("o_par_err_idle", 32'(pe_o), 0);
         chk("o_data_hold", 32'(dout_o), 32'(last_o));
      end
   end

   task automatic drive(input int sel, input logic b, input logic v, input logic rs);
      if (sel == 0) begin w_e = b; wv_e = v; rs_e = rs; end
      else          begin w_o = b; wv_o = v; rs_o = rs; end
   endtask

   task automatic send_bit(input int sel, input logic b);
      drive(sel, b, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_resync(input int sel, input logic b);
      drive(sel, b, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   // Expected result is computed from the frame itself, independent of the DUT.
   task automatic frame(input int sel, input logic [2:0] d, input logic p, input int gap);
      exp_t e;
      logic odd;
      odd  = (sel != 0);
      e.d  = d;
      e.pe = (((^d) ^ p) != odd);
      for (int i = 2; i >= 0; i--) begin
         send_bit(sel, d[i]);
         if (gap > 0) idle(gap);
      end
      if (sel == 0) begin
         if (e.pe && mcnt_e < 15) mcnt_e++;
         e.cnt = 4'(mcnt_e);
         q_e.push_back(e);
      end else begin
         if (e.pe && mcnt_o < 3) mcnt_o++;
         e.cnt = 4'(mcnt_o);
         q_o.push_back(e);
      end
      send_bit(sel, p);
   endtask

   initial begin
      rst_e = 1'b1; rst_o = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("e_rst_data", 32'(dout_e), 0);
      chk("e_rst_valid", 32'(dv_e), 0);
      chk("e_rst_cnt", 32'(cnt_e), 0);
      chk("o_rst_data", 32'(dout_o), 0);
      chk("o_rst_cnt", 32'(cnt_o), 0);
      @(posedge clk); #1;
      rst_e = 1'b0; rst_o = 1'b0;

      frame(0, 3'b101, 1'b0, 0);
      frame(0, 3'b011, 1'b1, 0);
      frame(0, 3'b110, 1'b0, 2);
      idle(2);

      send_bit(0, 1'b1);
      send_bit(0, 1'b1);
      do_resync(0, 1'b1);
      frame(0, 3'b001, 1'b1, 0);
      idle(1);

      // resync on the parity edge must swallow the frame
      send_bit(0, 1'b0);
      send_bit(0, 1'b0);
      send_bit(0, 1'b0);
      do_resync(0, 1'b1);
      idle(2);

      frame(0, 3'b111, 1'b0, 0);
      send_bit(0, 1'b1);
      send_bit(0, 1'b0);
      #1;
      rst_e  = 1'b1;
      q_e.delete();
      last_e = 3'b000;
      mcnt_e = 0;
      #1;
      chk("e_async_data", 32'(dout_e), 0);
      chk("e_async_valid", 32'(dv_e), 0);
      chk("e_async_par_err", 32'(pe_e), 0);
      chk("e_async_cnt", 32'(cnt_e), 0);
      #1;
      rst_e = 1'b0;
      frame(0, 3'b100, 1'b1, 0);
      idle(2);

      frame(1, 3'b101, 1'b0, 0);
      frame(1, 3'b000, 1'b0, 0);
      frame(1, 3'b110, 1'b0, 0);
      frame(1, 3'b111, 1'b1, 0);
      frame(1, 3'b010, 1'b1, 1);
      frame(1, 3'b101, 1'b1, 0);
      idle(3);

      chk("e_queue_drained", 32'(q_e.size()), 0);
      chk("o_queue_drained", 32'(q_o.size()), 0);
      chk("e_final_cnt", 32'(cnt_e), 32'(mcnt_e));
      chk("o_final_cnt", 32'(cnt_o), 32'(mcnt_o));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
